gcd_engine: RTL and testbench

Parametrised iterative greatest-common-divisor engine using the binary (Stein) algorithm: one shift or one subtract per cycle, no divider. It is the width-generic successor of the team's fixed 4-bit GCD wrapper. It adds a busy flag, a one-cycle done pulse, defined zero-operand results and an optional cycle-count output. It sits behind a simple start/done handshake and is driven directly by a testbench or a controlling FSM.

---
 rtl/gcd_pkg.sv | 28 ++
 rtl/gcd_step.sv | 46 ++++
 rtl/gcd_engine.sv | 175 +++++++++++++++++
 tb/tb_gcd_engine.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// ============================================================================
//  Module      : gcd_pkg
//  Description : Shared types, reset constants and width helper for the
//                binary-GCD engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ALIGN  = 2'd1,
        S_REDUCE = 2'd2,
        S_DONE   = 2'd3
    } gcd_state_e;

    localparam gcd_state_e C_RST_STATE = S_IDLE;
    localparam logic       C_RST_FLAG  = 1'b0;

    // Wide enough for the shift count and the worst-case iteration count.
    function automatic int gcd_cnt_w(input int width);
        return $clog2(4 * width + 4);
    endfunction

endpackage : gcd_pkg

`default_nettype wire

// File: rtl/gcd_step.sv
// ============================================================================
//  Module      : gcd_step
//  Description : Combinational single REDUCE step of the binary GCD
//                (halve an even operand, else subtract smaller from larger).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_a_nxt,
    output logic [WIDTH-1:0] o_b_nxt,
    output logic             o_eq
);

    logic w_a_even;
    logic w_b_even;
    logic w_a_gt_b;

    assign w_a_even = ~i_a[0];
    assign w_b_even = ~i_b[0];
    assign w_a_gt_b = (i_a > i_b);

    always_comb begin
        o_a_nxt = i_a;
        o_b_nxt = i_b;
        o_eq    = 1'b0;
        if (w_a_even) begin
            o_a_nxt = i_a >> 1;
        end else if (w_b_even) begin
            o_b_nxt = i_b >> 1;
        end else if (i_a == i_b) begin
            o_eq = 1'b1;
        end else if (w_a_gt_b) begin
            o_a_nxt = i_a - i_b;
        end else begin
            o_b_nxt = i_b - i_a;
        end
    end

endmodule : gcd_step

`default_nettype wire

// File: rtl/gcd_engine.sv
// ============================================================================
//  Module      : gcd_engine
//  Description : Iterative binary (Stein) GCD with start/done handshake.
//                Optional cycle counter output enabled by GCD_CYCLE_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_engine
    import gcd_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = gcd_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_A,
    input  logic [WIDTH-1:0] data_B,
    output logic [WIDTH-1:0] data_D,
    output logic             busy,
    output logic             done
`ifdef GCD_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0] cycles
`endif
);

    gcd_state_e r_state;
    gcd_state_e w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_k;

    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic             w_eq;
    logic             w_zero_op;
    logic             w_both_even;

    assign w_zero_op   = (data_A == '0) || (data_B == '0);
    assign w_both_even = ~r_a[0] & ~r_b[0];

    gcd_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_a     (r_a),
        .i_b     (r_b),
        .o_a_nxt (w_a_nxt),
        .o_b_nxt (w_b_nxt),
        .o_eq    (w_eq)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= C_RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = C_RST_FLAG;
        done        = C_RST_FLAG;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_zero_op ? S_DONE : S_ALIGN;
                end
            end
            S_ALIGN: begin
                busy = 1'b1;
                if (!w_both_even) begin
                    w_state_nxt = S_REDUCE;
                end
            end
            S_REDUCE: begin
                busy = 1'b1;
                if (w_eq) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: the common power of two is stripped in ALIGN and restored
    // when the result is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_k    <= '0;
            data_D <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a <= data_A;
                        r_b <= data_B;
                        r_k <= '0;
                        if (w_zero_op) begin
                            data_D <= data_A | data_B;
                        end
                    end
                end
                S_ALIGN: begin
                    if (w_both_even) begin
                        r_a <= r_a >> 1;
                        r_b <= r_b >> 1;
                        r_k <= r_k + CNT_W'(1);
                    end
                end
                S_REDUCE: begin
                    if (w_eq) begin
                        data_D <= r_a << r_k;
                    end else begin
                        r_a <= w_a_nxt;
                        r_b <= w_b_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef GCD_CYCLE_CNT_EN
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cycles;

    // r_cnt runs during the operation; r_cycles only moves at launch and
    // on the edge entering DONE so the output stays stable in between.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_cycles <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt    <= '0;
                        r_cycles <= '0;
                    end
                end
                S_ALIGN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_REDUCE: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_eq) begin
                        r_cycles <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cycles = r_cycles;
`endif

endmodule : gcd_engine

`default_nettype wire

// File: tb/tb_gcd_engine.sv
// ============================================================================
//  Module      : tb_gcd_engine
//  Description : Directed self-checking bench for gcd_engine at WIDTH 4 and 8.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gcd_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start4, start8;
    logic [3:0] a4, b4, d4;
    logic [7:0] a8, b8, d8;
    logic       busy4, done4, busy8, done8;
    logic [4:0] cyc4;
    logic [5:0] cyc8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gcd_engine #(.WIDTH(4)) u_dut4 (
        .clk    (clk),
        .reset  (reset),
        .start  (start4),
        .data_A (a4),
        .data_B (b4),
        .data_D (d4),
        .busy   (busy4),
        .done   (done4)
`ifdef GCD_CYCLE_CNT_EN
        ,
        .cycles (cyc4)
`endif
    );

    gcd_engine #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .reset  (reset),
        .start  (start8),
        .data_A (a8),
        .data_B (b8),
        .data_D (d8),
        .busy   (busy8),
        .done   (done8)
`ifdef GCD_CYCLE_CNT_EN
        ,
        .cycles (cyc8)
`endif
    );

`ifndef GCD_CYCLE_CNT_EN
    assign cyc4 = '0;
    assign cyc8 = '0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_d(input bit w8);
        return w8 ? 32'(d8) : 32'(d4);
    endfunction

    function automatic logic rd_done(input bit w8);
        return w8 ? done8 : done4;
    endfunction

    function automatic logic rd_busy(input bit w8);
        return w8 ? busy8 : busy4;
    endfunction

    function automatic logic [31:0] rd_cyc(input bit w8);
        return w8 ? 32'(cyc8) : 32'(cyc4);
    endfunction

    task automatic drive(input bit w8, input int a, input int b, input logic s);
        if (w8) begin
            a8 = a[7:0]; b8 = b[7:0]; start8 = s;
        end else begin
            a4 = a[3:0]; b4 = b[3:0]; start4 = s;
        end
    endtask

    // Entered one step after the launch edge; n counts cycles since launch.
    task automatic wait_done(input bit w8, output int n, output bit busy_ok);
        n       = 1;
        busy_ok = 1'b1;
        while (rd_done(w8) !== 1'b1 && n < 40) begin
            busy_ok &= (rd_busy(w8) === 1'b1);
            tick();
            n++;
        end
        busy_ok &= (rd_busy(w8) === 1'b1);
        chk("done_seen", 32'(rd_done(w8)), 32'd1);
    endtask

    task automatic op(input bit w8, input int a, input int b,
                      input int exp_d, input int exp_lat, input int exp_cyc);
        int n;
        bit ok;
        drive(w8, a, b, 1'b1);
        tick();
        if (w8) start8 = 1'b0; else start4 = 1'b0;
        wait_done(w8, n, ok);
        chk("latency", 32'(n), 32'(exp_lat));
        chk("data_D", rd_d(w8), 32'(exp_d));
        chk("busy_during", 32'(ok), 32'd1);
`ifdef GCD_CYCLE_CNT_EN
        chk("cycles", rd_cyc(w8), 32'(exp_cyc));
`else
        chk("cycles_absent", rd_cyc(w8) | 32'(exp_cyc & 0), 32'd0);
`endif
        tick();
        chk("done_fall", 32'(rd_done(w8)), 32'd0);
        chk("busy_fall", 32'(rd_busy(w8)), 32'd0);
    endtask

    initial begin
        int  n;
        bit  ok;
        reset  = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) tick();
        chk("rst_d4", 32'(d4), 32'd0);
        chk("rst_busy4", 32'(busy4), 32'd0);
        chk("rst_done4", 32'(done4), 32'd0);
        chk("rst_d8", 32'(d8), 32'd0);
        chk("rst_busy8", 32'(busy8), 32'd0);
        reset = 1'b0;
        tick();

        // WIDTH=4 directed vectors
        op(1'b0, 12, 4, 4, 7, 6);
        op(1'b0, 1, 1, 1, 3, 2);
        op(1'b0, 9, 6, 3, 6, 5);
        op(1'b0, 0, 9, 9, 1, 0);
        op(1'b0, 0, 0, 0, 1, 0);
        op(1'b0, 15, 0, 15, 1, 0);

        // WIDTH=8 directed vectors
        op(1'b1, 255, 254, 1, 24, 23);
        op(1'b1, 192, 128, 64, 12, 11);

        // start held high; operands changed while busy
        drive(1'b0, 12, 15, 1'b1);
        tick();
        drive(1'b0, 8, 4, 1'b1);
        wait_done(1'b0, n, ok);
        chk("held_lat", 32'(n), 32'd8);
        chk("held_d", 32'(d4), 32'd3);
        chk("held_busy", 32'(ok), 32'd1);
        tick();
        chk("held_idle", 32'(busy4), 32'd0);
        tick();
        chk("held_relaunch", 32'(busy4), 32'd1);
        start4 = 1'b0;
        wait_done(1'b0, n, ok);
        chk("held2_lat", 32'(n), 32'd6);
        chk("held2_d", 32'(d4), 32'd4);
        tick();

        // reset asserted mid-REDUCE
        drive(1'b1, 255, 254, 1'b1);
        tick();
        start8 = 1'b0;
        repeat (5) tick();
        chk("mid_busy", 32'(busy8), 32'd1);
        reset = 1'b1;
        tick();
        chk("rst_mid_busy", 32'(busy8), 32'd0);
        chk("rst_mid_done", 32'(done8), 32'd0);
        chk("rst_mid_d", 32'(d8), 32'd0);
`ifdef GCD_CYCLE_CNT_EN
        chk("rst_mid_cycles", 32'(cyc8), 32'd0);
`endif
        reset = 1'b0;
        tick();
        op(1'b1, 12, 4, 4, 7, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_gcd_engine

`default_nettype wire
